sdram_mac_split: RTL and testbench

SDRAM_MAC_SPLIT -- requirements
Module: sdram_mac_split

---
 rtl/sdram_mac_pkg.sv | 20 ++
 rtl/sdram_mac_split_buffer_ram_conv.sv | 53 +++++
 rtl/sdram_mac_split.sv | 158 +++++++++++++++
 tb/tb_sdram_mac_split.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_mac_pkg.sv
// rtl/sdram_mac_pkg.sv - shared widths, FSM state type and chunk sizing helper
package sdram_mac_pkg;

    localparam int DEF_HOST_W = 32;
    localparam int DEF_MEM_W  = 16;
    localparam int DEF_LEN_W  = 9;
    localparam int DEF_ADDR_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_FIN
    } state_t;

    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_mac_split_buffer_ram_conv.sv
// rtl/sdram_mac_split_buffer_ram_conv.sv - width-converting simple dual-port buffer RAM
module buffer_ram_conv #(
    parameter int WIDE_W   = 32,
    parameter int NARROW_W = 16,
    parameter int DEPTH_W  = 9,
    parameter bit WIDE_WR  = 1'b1,
    localparam int RATIO   = WIDE_W / NARROW_W,
    localparam int WIDE_AW = DEPTH_W - $clog2(RATIO),
    localparam int WR_W    = WIDE_WR ? WIDE_W : NARROW_W,
    localparam int RD_W    = WIDE_WR ? NARROW_W : WIDE_W,
    localparam int WA_W    = WIDE_WR ? WIDE_AW : DEPTH_W,
    localparam int RA_W    = WIDE_WR ? DEPTH_W : WIDE_AW
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [WA_W-1:0] wr_addr,
    input  logic [WR_W-1:0] wr_data,
    input  logic [RA_W-1:0] rd_addr,
    output logic [RD_W-1:0] rd_data
);

    // Storage is always in narrow words; wide word k maps little-endian onto k*RATIO..k*RATIO+RATIO-1.
    logic [NARROW_W-1:0] mem [2**DEPTH_W];

    generate
        if (WIDE_WR) begin : g_wide_to_narrow
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int i = 0; i < RATIO; i++) begin
                        mem[DEPTH_W'(int'(wr_addr) * RATIO + i)] <= wr_data[i*NARROW_W +: NARROW_W];
                    end
                end
            end

            always_ff @(posedge clk) begin
                rd_data <= mem[rd_addr];
            end
        end else begin : g_narrow_to_wide
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < RATIO; i++) begin
                    rd_data[i*NARROW_W +: NARROW_W] <= mem[DEPTH_W'(int'(rd_addr) * RATIO + i)];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sdram_mac_split.sv
// rtl/sdram_mac_split.sv - host buffer front end that splits transfers into core-sized bursts
module sdram_mac_split
    import sdram_mac_pkg::*;
#(
    parameter int HOST_W = DEF_HOST_W,
    parameter int MEM_W  = DEF_MEM_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int RATIO = HOST_W / MEM_W,
    localparam int HA_W  = LEN_W - $clog2(RATIO)
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [HA_W-1:0]   ADDR,
    input  logic [HOST_W-1:0] WD,
    output logic [HOST_W-1:0] RD,
    input  logic              WE,
    input  logic              WE_LEN,
    input  logic              WE_A,
    output logic              BUSY,
    output logic              DONE,
    output logic              CORE_REQUEST,
    output logic              CORE_WRITE,
    output logic [LEN_W-1:0]  CORE_LENGTH,
    output logic [ADDR_W-1:0] CORE_ADDR,
    input  logic [LEN_W-1:0]  CORE_MAX_LEN,
    input  logic              CORE_BUSY,
    input  logic              CORE_WR_ADV,
    input  logic              CORE_RD_ADV,
    output logic [MEM_W-1:0]  CORE_DATA_IN,
    input  logic [MEM_W-1:0]  CORE_DATA_OUT
);

    state_t             state, state_nxt;
    logic               start, issue, retire;
    logic               write_flag;
    logic [LEN_W-1:0]   rem_len, chunk;
    logic [LEN_W-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr;
    logic [ADDR_W-1:0]  cur_addr, addr_reg;

    assign chunk = LEN_W'(min_len(32'(rem_len), 32'(CORE_MAX_LEN)));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        issue     = 1'b0;
        retire    = 1'b0;
        DONE      = 1'b0;
        BUSY      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (WE_LEN) begin
                    start     = 1'b1;
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (rem_len == '0) begin
                    state_nxt = ST_FIN;
                end else if (!CORE_BUSY && CORE_MAX_LEN != '0) begin
                    issue     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // The core only has to raise CORE_BUSY the cycle after the request, so skip that cycle.
                if (!CORE_REQUEST && !CORE_BUSY) begin
                    retire    = 1'b1;
                    state_nxt = ST_ARMED;
                end
            end
            ST_FIN: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Look-ahead pointer so the registered buffer read lands on CORE_DATA_IN for the current wr_ptr.
    assign wr_ptr_nxt = start       ? '0 :
                        CORE_WR_ADV ? wr_ptr + LEN_W'(1) : wr_ptr;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            CORE_REQUEST <= 1'b0;
            CORE_LENGTH  <= '0;
            CORE_ADDR    <= '0;
            CORE_WRITE   <= 1'b0;
            write_flag   <= 1'b0;
            rem_len      <= '0;
            cur_addr     <= '0;
            addr_reg     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            CORE_REQUEST <= issue;
            wr_ptr       <= wr_ptr_nxt;
            if (WE_A) begin
                addr_reg <= WD[ADDR_W-1:0];
            end
            if (start) begin
                write_flag <= WD[HOST_W-1];
                rem_len    <= WD[LEN_W-1:0];
                cur_addr   <= addr_reg;
                rd_ptr     <= '0;
            end else if (CORE_RD_ADV) begin
                rd_ptr <= rd_ptr + LEN_W'(1);
            end
            if (issue) begin
                CORE_LENGTH <= chunk;
                CORE_ADDR   <= cur_addr;
                CORE_WRITE  <= write_flag;
            end
            if (retire) begin
                rem_len  <= rem_len - CORE_LENGTH;
                cur_addr <= cur_addr + ADDR_W'(CORE_LENGTH);
            end
        end
    end

    buffer_ram_conv #(
        .WIDE_W   (HOST_W),
        .NARROW_W (MEM_W),
        .DEPTH_W  (LEN_W),
        .WIDE_WR  (1'b1)
    ) u_wr_buf (
        .clk     (CLK),
        .wr_en   (WE),
        .wr_addr (ADDR),
        .wr_data (WD),
        .rd_addr (wr_ptr_nxt),
        .rd_data (CORE_DATA_IN)
    );

    buffer_ram_conv #(
        .WIDE_W   (HOST_W),
        .NARROW_W (MEM_W),
        .DEPTH_W  (LEN_W),
        .WIDE_WR  (1'b0)
    ) u_rd_buf (
        .clk     (CLK),
        .wr_en   (CORE_RD_ADV),
        .wr_addr (rd_ptr),
        .wr_data (CORE_DATA_OUT),
        .rd_addr (ADDR),
        .rd_data (RD)
    );

endmodule

// File: tb/tb_sdram_mac_split.sv
// tb/tb_sdram_mac_split.sv - scoreboard bench for sdram_mac_split with a behavioural core
module tb_sdram_mac_split;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [7:0]  ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        WE, WE_LEN, WE_A;
    logic        BUSY, DONE;
    logic        CORE_REQUEST, CORE_WRITE;
    logic [8:0]  CORE_LENGTH;
    logic [23:0] CORE_ADDR;
    logic [8:0]  CORE_MAX_LEN;
    logic        CORE_BUSY, CORE_WR_ADV, CORE_RD_ADV;
    logic [15:0] CORE_DATA_IN, CORE_DATA_OUT;

    always #5 CLK = ~CLK;

    sdram_mac_split dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .ADDR          (ADDR),
        .WD            (WD),
        .RD            (RD),
        .WE            (WE),
        .WE_LEN        (WE_LEN),
        .WE_A          (WE_A),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .CORE_REQUEST  (CORE_REQUEST),
        .CORE_WRITE    (CORE_WRITE),
        .CORE_LENGTH   (CORE_LENGTH),
        .CORE_ADDR     (CORE_ADDR),
        .CORE_MAX_LEN  (CORE_MAX_LEN),
        .CORE_BUSY     (CORE_BUSY),
        .CORE_WR_ADV   (CORE_WR_ADV),
        .CORE_RD_ADV   (CORE_RD_ADV),
        .CORE_DATA_IN  (CORE_DATA_IN),
        .CORE_DATA_OUT (CORE_DATA_OUT)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_seen = 0;
    logic        rd_chk = 1'b0;
    logic [15:0] rd_pat = 16'h0000;
    logic [33:0] exp_req[$];
    logic [15:0] exp_wdata[$];
    logic [31:0] exp_rd[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected nothing", name, got);
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (CORE_REQUEST) begin
                if (exp_req.size() == 0) unexpected("core_req", {CORE_WRITE, CORE_LENGTH, CORE_ADDR});
                else check("core_req", {CORE_WRITE, CORE_LENGTH, CORE_ADDR}, exp_req.pop_front());
            end
            if (CORE_WR_ADV) begin
                if (exp_wdata.size() == 0) unexpected("core_wdata", CORE_DATA_IN);
                else check("core_wdata", CORE_DATA_IN, exp_wdata.pop_front());
            end
            if (rd_chk) begin
                if (exp_rd.size() == 0) unexpected("rd_data", RD);
                else check("rd_data", RD, exp_rd.pop_front());
            end
            if (DONE) done_seen++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Behavioural SDRAM core: busy from the request cycle, one advance per cycle, abort on reset.
    task automatic serve();
        int   n;
        logic wr;
        n  = int'(CORE_LENGTH);
        wr = CORE_WRITE;
        CORE_BUSY = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            if (!RESETn) break;
            if (wr) begin
                CORE_WR_ADV = 1'b1;
            end else begin
                CORE_RD_ADV   = 1'b1;
                CORE_DATA_OUT = rd_pat;
                rd_pat        = rd_pat + 16'd1;
            end
            tick();
        end
        CORE_WR_ADV = 1'b0;
        CORE_RD_ADV = 1'b0;
        CORE_BUSY   = 1'b0;
    endtask

    initial begin
        CORE_BUSY     = 1'b0;
        CORE_WR_ADV   = 1'b0;
        CORE_RD_ADV   = 1'b0;
        CORE_DATA_OUT = '0;
        forever begin
            tick();
            if (RESETn && CORE_REQUEST) serve();
        end
    end

    task automatic host_wr(input int k, input logic [31:0] d);
        ADDR = 8'(k);
        WD   = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic load_addr(input logic [31:0] a);
        WD   = a;
        WE_A = 1'b1;
        tick();
        WE_A = 1'b0;
    endtask

    task automatic start_xfer(input logic [31:0] w);
        WD     = w;
        WE_LEN = 1'b1;
        tick();
        WE_LEN = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int t;
        t = 0;
        while (done_seen < target && t < 5000) begin
            tick();
            t++;
        end
        tick(3);
        check(name, done_seen, target);
    endtask

    task automatic wait_core_busy(input string name);
        int t;
        t = 0;
        while (!CORE_BUSY && t < 100) begin
            tick();
            t++;
        end
        check(name, CORE_BUSY, 1);
    endtask

    task automatic drain_check(input string name);
        check({name, "_req_left"}, exp_req.size(), 0);
        check({name, "_wdata_left"}, exp_wdata.size(), 0);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        RESETn = 1'b0;
        WE = 1'b0; WE_LEN = 1'b0; WE_A = 1'b0;
        ADDR = '0; WD = '0;
        CORE_MAX_LEN = 9'd256;
        tick(3);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_req", CORE_REQUEST, 0);
        check("rst_len", CORE_LENGTH, 0);
        check("rst_addr", CORE_ADDR, 0);
        check("rst_write", CORE_WRITE, 0);
        RESETn = 1'b1;
        tick(2);

        // Write of 8 words, single burst, packed low half first.
        load_addr(32'h0000_1234);
        for (int k = 0; k < 4; k++) host_wr(k, {16'(16'hA101 + 2 * k), 16'(16'hA100 + 2 * k)});
        exp_req.push_back({1'b1, 9'd8, 24'h001234});
        for (int n = 0; n < 8; n++) exp_wdata.push_back(16'(16'hA100 + n));
        start_xfer(32'h8000_0008);
        wait_done(1, "wr8_done");
        drain_check("wr8");

        // Read of 300 words across the top of the address space.
        load_addr(32'h00FF_FF00);
        rd_pat = 16'h5000;
        exp_req.push_back({1'b0, 9'd256, 24'hFFFF00});
        exp_req.push_back({1'b0, 9'd44, 24'h000000});
        start_xfer(32'd300);
        wait_done(2, "rd300_done");
        drain_check("rd300");
        ADDR = 8'd0;
        for (int k = 0; k < 150; k++) begin
            tick();
            exp_rd.push_back({16'(16'h5001 + 2 * k), 16'(16'h5000 + 2 * k)});
            rd_chk = 1'b1;
            ADDR   = 8'(k + 1);
        end
        tick();
        rd_chk = 1'b0;
        check("rd300_rd_left", exp_rd.size(), 0);

        // Zero length: two busy cycles, DONE on the second, no request.
        start_xfer(32'h0000_0000);
        busy_cnt = 0;
        done_at  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (BUSY) busy_cnt++;
            if (DONE) done_at = busy_cnt;
        end
        tick();
        check("len0_busy_cycles", busy_cnt, 2);
        check("len0_done_cycle", done_at, 2);
        check("len0_done_count", done_seen, 3);

        // Core limit of zero stalls in ARMED, then 64-word chunks.
        load_addr(32'h0000_0100);
        CORE_MAX_LEN = 9'd0;
        start_xfer(32'd100);
        tick(20);
        check("max0_busy_hold", BUSY, 1);
        exp_req.push_back({1'b0, 9'd64, 24'h000100});
        exp_req.push_back({1'b0, 9'd36, 24'h000140});
        CORE_MAX_LEN = 9'd64;
        wait_done(4, "max0_done");
        drain_check("max0");
        CORE_MAX_LEN = 9'd256;

        // Reset during RUN aborts without DONE; next transfer starts from buffer word 0.
        load_addr(32'h0000_0300);
        exp_req.push_back({1'b0, 9'd200, 24'h000300});
        start_xfer(32'd200);
        wait_core_busy("rst_run_core_busy");
        tick(5);
        @(negedge CLK);
        RESETn = 1'b0;
        #1;
        check("rst_run_busy", BUSY, 0);
        check("rst_run_req", CORE_REQUEST, 0);
        check("rst_run_len", CORE_LENGTH, 0);
        check("rst_run_addr", CORE_ADDR, 0);
        check("rst_run_done", DONE, 0);
        tick(2);
        RESETn = 1'b1;
        tick(2);
        check("rst_run_no_done", done_seen, 4);
        load_addr(32'h0000_0050);
        exp_req.push_back({1'b1, 9'd4, 24'h000050});
        for (int n = 0; n < 4; n++) exp_wdata.push_back(16'(16'hA100 + n));
        start_xfer(32'h8000_0004);
        wait_done(5, "post_rst_done");
        drain_check("post_rst");

        // WE_LEN while busy is ignored.
        load_addr(32'h0000_0200);
        CORE_MAX_LEN = 9'd8;
        exp_req.push_back({1'b0, 9'd8, 24'h000200});
        exp_req.push_back({1'b0, 9'd8, 24'h000208});
        exp_req.push_back({1'b0, 9'd4, 24'h000210});
        start_xfer(32'd20);
        wait_core_busy("busy_wl_core_busy");
        start_xfer(32'h8000_0005);
        wait_done(6, "busy_wl_done");
        drain_check("busy_wl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
